// File: rtl/io_pkg.sv
// Shared definitions for the I/O side of the bus: I/O address select bits,
// UART status bit positions and the UART transmitter state encoding.
package io_pkg;

  // Address bit that selects each I/O peripheral
  localparam int unsigned LEDS = 2;
  localparam int unsigned HEX  = 3;
  localparam int unsigned KEY  = 4;
  localparam int unsigned SW   = 5;
  localparam int unsigned UART = 6;

  // Bit positions inside the UART status word
  localparam int unsigned BUSY  = 0;
  localparam int unsigned EMPTY = 1;
  localparam int unsigned FULL  = 2;
  localparam int unsigned OVF   = 3;

  localparam int unsigned STATUS_W = 32;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers.
// Ports: clk, reset_n (async, active-low); push/wdata enqueue at the tail;
// pop dequeues the head; full/empty/head are decoded from registered pointers
// and the storage array, so they carry no path from push or pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Pointer MSB acts as a lap flag to tell full apart from empty
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO.
// Ports: clk, reset_n (async, active-low); tx_we/tx_data enqueue one byte per
// store; txd is the serial line (idle high, straight from a flop); status is
// {28'b0, overflow, full, empty, busy}, built only from registered state.
module io_uart_tx
  import io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tx_we,
  input  logic [7:0]          tx_data,
  output logic                txd,
  output logic [STATUS_W-1:0] status
);

  localparam int unsigned               BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]         BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              ovf_q, ovf_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_head;
  logic              baud_wrap;

  // Full is the pre-edge value, so a store racing a pop from a full FIFO is lost
  assign fifo_push = tx_we & ~fifo_full;
  assign ovf_d     = ovf_q | (tx_we & fifo_full);
  assign baud_wrap = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (tx_data),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // Frame sequencing; txd_d is the line level for the cycle after this edge
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    fifo_pop  = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = START;
          txd_d    = 1'b0;
        end
      end
      START: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          state_d   = DATA;
          bit_idx_d = '0;
          txd_d     = shift_q[0];
        end
      end
      DATA: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      STOP: begin
        baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);
        if (baud_wrap) begin
          // Chain straight into the next frame when more data is queued
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = START;
            txd_d    = 1'b0;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign txd = txd_q;

  // Status word for the I/O read mux
  always_comb begin
    status        = '0;
    status[BUSY]  = (state_q != IDLE);
    status[EMPTY] = fifo_empty;
    status[FULL]  = fifo_full;
    status[OVF]   = ovf_q;
  end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: a line monitor decodes every frame on txd and checks
// it cycle by cycle against bytes queued by the stimulus tasks.
module tb_io_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        tx_we   = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        txd;
  logic [31:0] status;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]       exp_q[$];
  logic [7:0]       mon_exp;
  logic [FRAME-1:0] got;
  logic [FRAME-1:0] want;
  int               frames   = 0;
  int               gap      = 0;
  int               last_gap = 0;
  int               mon_cnt  = 0;
  bit               in_frame = 1'b0;

  always #5 clk = ~clk;

  io_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tx_we   (tx_we),
    .tx_data (tx_data),
    .txd     (txd),
    .status  (status)
  );

  // Expected per-cycle line levels of one 8N1 frame, LSB first
  function automatic logic [FRAME-1:0] frame_pat(input logic [7:0] b);
    logic [FRAME-1:0] p;
    int s;
    p = '0;
    for (int i = 0; i < int'(FRAME); i++) begin
      s = i / int'(CPB);
      if (s == 0)      p[i] = 1'b0;
      else if (s == 9) p[i] = 1'b1;
      else             p[i] = b[s-1];
    end
    return p;
  endfunction

  // Line monitor: a frame begins on the first low sample while idle
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      mon_cnt  = 0;
      gap      = 0;
    end else if (!in_frame) begin
      if (txd === 1'b0) begin
        in_frame = 1'b1;
        got      = '0;
        got[0]   = txd;
        mon_cnt  = 1;
        last_gap = gap;
        gap      = 0;
      end else begin
        gap++;
      end
    end else begin
      got[mon_cnt] = txd;
      mon_cnt++;
      if (mon_cnt == int'(FRAME)) begin
        in_frame = 1'b0;
        frames++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL frame_unexpected: got %b, required no frame", got);
        end else begin
          mon_exp = exp_q.pop_front();
          want    = frame_pat(mon_exp);
          if (got !== want) begin
            miscompares++;
            $display("FAIL frame_0x%h: got %b, required %b", mon_exp, got, want);
          end
        end
      end
    end
  end

  task automatic apply_reset;
    @(negedge clk);
    reset_n = 1'b0;
    tx_we   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    tx_we   = 1'b1;
    tx_data = b;
    @(posedge clk);
  endtask

  task automatic wr_end;
    @(negedge clk);
    tx_we = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (frames < target) begin
      miscompares++;
      $display("FAIL frame_timeout: got %0d frames, required %0d", frames, target);
    end
  endtask

  task automatic test_reset;
    int bad;
    apply_reset();
    vectors++;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_txd: got %b, required 1", txd);
    end
    vectors++;
    if (status !== 32'h2) begin
      miscompares++;
      $display("FAIL reset_status: got %h, required 00000002", status);
    end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || status !== 32'h2) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_idle_hold: got %0d disturbed cycles, required 0", bad);
    end
  endtask

  task automatic test_single_byte;
    int f0, busy_cnt;
    f0 = frames;
    exp_q.push_back(8'h55);
    wr(8'h55);
    wr_end();
    vectors++;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL single_txd_before_pop: got %b, required 1", txd);
    end
    vectors++;
    if (status !== 32'h0) begin
      miscompares++;
      $display("FAIL single_status_queued: got %h, required 00000000", status);
    end
    @(negedge clk);
    vectors++;
    if (txd !== 1'b0) begin
      miscompares++;
      $display("FAIL single_start_edge: got %b, required 0", txd);
    end
    busy_cnt = status[0] ? 1 : 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (status[0]) busy_cnt++;
    end
    vectors++;
    if (busy_cnt != int'(FRAME)) begin
      miscompares++;
      $display("FAIL single_busy_len: got %0d, required %0d", busy_cnt, FRAME);
    end
    wait_frames(f0 + 1, 100);
    vectors++;
    if (status !== 32'h2) begin
      miscompares++;
      $display("FAIL single_status_done: got %h, required 00000002", status);
    end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = frames;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    wr(8'hA3);
    wr(8'h0F);
    wr_end();
    repeat (39) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (status !== 32'h1) begin
      miscompares++;
      $display("FAIL b2b_status_before_pop: got %h, required 00000001", status);
    end
    @(negedge clk);
    vectors++;
    if (status !== 32'h3) begin
      miscompares++;
      $display("FAIL b2b_status_after_pop: got %h, required 00000003", status);
    end
    wait_frames(f0 + 2, 100);
    vectors++;
    if (last_gap != 0) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d idle cycles, required 0", last_gap);
    end
  endtask

  task automatic test_overflow;
    int f0;
    f0 = frames;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 1; i <= 6; i++) wr(8'(i));
    wr_end();
    vectors++;
    if (status !== 32'hD) begin
      miscompares++;
      $display("FAIL ovf_status_full: got %h, required 0000000d", status);
    end
    wait_frames(f0 + 5, 5 * int'(FRAME) + 100);
    repeat (5) @(negedge clk);
    vectors++;
    if (status !== 32'hA) begin
      miscompares++;
      $display("FAIL ovf_status_sticky: got %h, required 0000000a", status);
    end
    vectors++;
    if (last_gap != 0) begin
      miscompares++;
      $display("FAIL ovf_gap: got %0d idle cycles, required 0", last_gap);
    end
  endtask

  task automatic test_write_on_pop_full;
    int f0;
    apply_reset();
    f0 = frames;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(8'hC0 + i));
    for (int i = 1; i <= 5; i++) wr(8'(8'hC0 + i));
    wr_end();
    repeat (36) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (status !== 32'h5) begin
      miscompares++;
      $display("FAIL popfull_status_before: got %h, required 00000005", status);
    end
    tx_we   = 1'b1;
    tx_data = 8'h77;
    @(posedge clk);
    @(negedge clk);
    tx_we = 1'b0;
    vectors++;
    if (status !== 32'h9) begin
      miscompares++;
      $display("FAIL popfull_status_after: got %h, required 00000009", status);
    end
    wait_frames(f0 + 5, 5 * int'(FRAME) + 100);
    repeat (int'(FRAME) + 10) @(negedge clk);
    vectors++;
    if (status !== 32'hA || frames != f0 + 5) begin
      miscompares++;
      $display("FAIL popfull_end: got status %h frames %0d, required 0000000a frames %0d",
               status, frames - f0, 5);
    end
  endtask

  task automatic test_reset_mid_frame;
    int f0, bad;
    f0 = frames;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    wr_end();
    repeat (16) @(posedge clk);
    #3;
    vectors++;
    if (txd !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_bit3_before: got %b, required 0", txd);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_txd_async: got %b, required 1", txd);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    vectors++;
    if (status !== 32'h2) begin
      miscompares++;
      $display("FAIL midrst_status: got %h, required 00000002", status);
    end
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0 || frames != f0) begin
      miscompares++;
      $display("FAIL midrst_quiet: got %0d low cycles %0d frames, required 0 and 0",
               bad, frames - f0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_write_on_pop_full();
    test_reset_mid_frame();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
